// File: rtl/spi_txn_scheduler_if.sv
// Bundle of requester-side and engine-side signals of the SPI transaction scheduler.
// slave  : the scheduler's view (consumes i_*, drives o_*).
// master : the environment's view (requesters plus byte engine).
interface spi_txn_scheduler_if #(
    parameter int NUM_REQ = 4
);
    // requester side
    logic [NUM_REQ-1:0]    i_req;
    logic [10*NUM_REQ-1:0] i_req_cfg;
    logic [8*NUM_REQ-1:0]  i_req_len;
    logic [8*NUM_REQ-1:0]  i_tx_data;
    logic [NUM_REQ-1:0]    o_gnt;
    logic                  o_tx_pop;
    logic [7:0]            o_rx_data;
    logic                  o_rx_valid;
    logic [NUM_REQ-1:0]    o_done;
    logic [NUM_REQ-1:0]    o_error;
    logic [NUM_REQ-1:0]    o_cs_n;

    // byte engine side
    logic [10:0]           o_spi_config;
    logic [7:0]            o_spi_tx;
    logic                  o_spi_tx_valid;
    logic [7:0]            i_spi_rx;
    logic                  i_spi_rx_valid;
    logic                  i_spi_ready;

    modport slave (
        input  i_req, i_req_cfg, i_req_len, i_tx_data,
        input  i_spi_rx, i_spi_rx_valid, i_spi_ready,
        output o_gnt, o_tx_pop, o_rx_data, o_rx_valid, o_done, o_error, o_cs_n,
        output o_spi_config, o_spi_tx, o_spi_tx_valid
    );

    modport master (
        output i_req, i_req_cfg, i_req_len, i_tx_data,
        output i_spi_rx, i_spi_rx_valid, i_spi_ready,
        input  o_gnt, o_tx_pop, o_rx_data, o_rx_valid, o_done, o_error, o_cs_n,
        input  o_spi_config, o_spi_tx, o_spi_tx_valid
    );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI byte engine among NUM_REQ requesters.
// Each transaction: arbitrate, (re)program engine config only if it differs from
// the cached one, assert CS with setup time, stream len bytes, hold CS, pulse done.
// Any engine wait step lasting TIMEOUT cycles aborts with an error pulse.
// CS_SETUP and CS_HOLD must be at least 1.
module spi_txn_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 4096
) (
    input logic                i_clk,
    input logic                i_rst_n,
    spi_txn_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CFG_ISSUE,
        ST_CFG_BUSY,
        ST_CFG_READY,
        ST_CS_SETUP,
        ST_TX_ISSUE,
        ST_TX_BUSY,
        ST_TX_RX,
        ST_CS_HOLD,
        ST_FINISH
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx_q;
    logic [9:0]         cfg_q;
    logic [7:0]         rem_q;
    logic [9:0]         cache_q;
    logic               cache_vld;
    logic               err_q;
    logic [7:0]         rx_data_q;
    logic               rx_valid_q;

    logic [9:0]         cfg_arr [NUM_REQ];
    logic [7:0]         len_arr [NUM_REQ];
    logic [7:0]         tx_arr  [NUM_REQ];
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      ptr_next;
    logic [NUM_REQ-1:0] sel;
    logic               wait_st;
    logic               tmo_hit;
    logic               abort;

    assign wait_st  = state_q inside {ST_CFG_ISSUE, ST_CFG_BUSY, ST_CFG_READY,
                                      ST_TX_ISSUE, ST_TX_BUSY, ST_TX_RX};
    assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));
    assign abort    = wait_st && (state_d == ST_IDLE);
    assign sel      = NUM_REQ'(1) << idx_q;
    assign ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    assign bus.o_rx_data  = rx_data_q;
    assign bus.o_rx_valid = rx_valid_q;

    // Split the packed per-requester buses into indexable arrays.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            cfg_arr[r] = bus.i_req_cfg[r*10 +: 10];
            len_arr[r] = bus.i_req_len[r*8 +: 8];
            tx_arr[r]  = bus.i_tx_data[r*8 +: 8];
        end
    end

    // Round-robin pick: first active request at or above the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.i_req[IW'((32'(rr_ptr) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = IW'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every engine wait falls back to IDLE on timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (|bus.i_req) state_d = ST_ARB;
            ST_ARB: begin
                if (!win_found)                                         state_d = ST_IDLE;
                else if (len_arr[win_idx] == 8'd0)                      state_d = ST_FINISH;
                else if (cache_vld && (cfg_arr[win_idx] == cache_q))    state_d = ST_CS_SETUP;
                else                                                    state_d = ST_CFG_ISSUE;
            end
            ST_CFG_ISSUE: if (bus.i_spi_ready)       state_d = ST_CFG_BUSY;
                          else if (tmo_hit)          state_d = ST_IDLE;
            ST_CFG_BUSY:  if (!bus.i_spi_ready)      state_d = ST_CFG_READY;
                          else if (tmo_hit)          state_d = ST_IDLE;
            ST_CFG_READY: if (bus.i_spi_ready)       state_d = ST_CS_SETUP;
                          else if (tmo_hit)          state_d = ST_IDLE;
            ST_CS_SETUP:  if (cnt_q == CW'(CS_SETUP - 1)) state_d = ST_TX_ISSUE;
            ST_TX_ISSUE:  if (bus.i_spi_ready)       state_d = ST_TX_BUSY;
                          else if (tmo_hit)          state_d = ST_IDLE;
            // rx_valid still reflects the previous byte until ready drops
            ST_TX_BUSY:   if (!bus.i_spi_ready)      state_d = ST_TX_RX;
                          else if (tmo_hit)          state_d = ST_IDLE;
            ST_TX_RX:     if (bus.i_spi_rx_valid)    state_d = (rem_q == 8'd1) ? ST_CS_HOLD : ST_TX_ISSUE;
                          else if (tmo_hit)          state_d = ST_IDLE;
            ST_CS_HOLD:   if (cnt_q == CW'(CS_HOLD - 1)) state_d = ST_FINISH;
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; engine strobes only while ready.
    always_comb begin
        bus.o_gnt          = '0;
        bus.o_cs_n         = '1;
        bus.o_spi_config   = '0;
        bus.o_spi_tx       = '0;
        bus.o_spi_tx_valid = 1'b0;
        bus.o_tx_pop       = 1'b0;
        bus.o_done         = '0;
        bus.o_error        = '0;
        case (state_q)
            ST_CFG_ISSUE: begin
                bus.o_gnt = sel;
                if (bus.i_spi_ready) bus.o_spi_config = {cfg_q, 1'b1};
            end
            ST_CFG_BUSY, ST_CFG_READY: bus.o_gnt = sel;
            ST_CS_SETUP, ST_TX_BUSY, ST_TX_RX, ST_CS_HOLD: begin
                bus.o_gnt  = sel;
                bus.o_cs_n = ~sel;
            end
            ST_TX_ISSUE: begin
                bus.o_gnt  = sel;
                bus.o_cs_n = ~sel;
                if (bus.i_spi_ready) begin
                    bus.o_spi_tx       = tx_arr[idx_q];
                    bus.o_spi_tx_valid = 1'b1;
                    bus.o_tx_pop       = 1'b1;
                end
            end
            ST_FINISH: bus.o_done = sel;
            default: ;
        endcase
        // error is flagged one cycle after the abort, when CS is already released
        if (err_q) bus.o_error = sel;
    end

    // Dwell counter shared by CS timing and timeout; cleared on each state change.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Transaction context, config cache, rx capture and error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr     <= '0;
            idx_q      <= '0;
            cfg_q      <= '0;
            rem_q      <= '0;
            cache_q    <= '0;
            cache_vld  <= 1'b0;
            err_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            err_q      <= abort;
            if (state_q == ST_ARB && win_found) begin
                idx_q  <= win_idx;
                cfg_q  <= cfg_arr[win_idx];
                rem_q  <= len_arr[win_idx];
                rr_ptr <= ptr_next;
            end
            if (state_q == ST_CFG_READY && bus.i_spi_ready) begin
                cache_q   <= cfg_q;
                cache_vld <= 1'b1;
            end
            if (state_q == ST_TX_RX && bus.i_spi_rx_valid) begin
                rx_data_q  <= bus.i_spi_rx;
                rx_valid_q <= 1'b1;
                rem_q      <= rem_q - 1'b1;
            end
            if (abort) cache_vld <= 1'b0;
        end
    end

endmodule
